// File: rtl/axi4_lite_pkg.sv
// AXI4-Lite shared types: bus field widths, response codes and the
// single-outstanding master FSM state encoding.
package axi4_lite_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
  localparam int unsigned AXI_RESP_W = 2;

  typedef logic [AXI_ADDR_W-1:0] axi_lite_addr_t;
  typedef logic [AXI_DATA_W-1:0] axi_lite_data_t;
  typedef logic [AXI_STRB_W-1:0] axi_lite_strb_t;
  typedef logic [AXI_RESP_W-1:0] axi_lite_resp_t;

  localparam axi_lite_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_lite_resp_t AXI_RESP_SLVERR = 2'b10;
  localparam axi_lite_resp_t AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } axi_master_state_e;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns one command on the
// cmd_* port into one AXI4-Lite read or write and returns the result on
// the rsp_* port. AW and W are issued together and may be accepted in
// either order or in the same cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata/wstrb   command request (cmd_ready is combinational)
//   rsp_valid/ready/rdata/resp/timeout       response return
//   aw*, w*, b*, ar*, r*     AXI4-Lite master channels
//
// Build option: define AXI_MASTER_TIMEOUT_EN to compile in a per-state
// watchdog that aborts after TIMEOUT_CYCLES cycles with DECERR and
// rsp_timeout=1. Without it the master waits indefinitely.
module axi_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_write,
  input  axi_lite_addr_t cmd_addr,
  input  axi_lite_data_t cmd_wdata,
  input  axi_lite_strb_t cmd_wstrb,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output axi_lite_data_t rsp_rdata,
  output axi_lite_resp_t rsp_resp,
  output logic           rsp_timeout,
  output axi_lite_addr_t awaddr,
  output logic           awvalid,
  input  logic           awready,
  output axi_lite_data_t wdata,
  output axi_lite_strb_t wstrb,
  output logic           wvalid,
  input  logic           wready,
  input  axi_lite_resp_t bresp,
  input  logic           bvalid,
  output logic           bready,
  output axi_lite_addr_t araddr,
  output logic           arvalid,
  input  logic           arready,
  input  axi_lite_data_t rdata,
  input  axi_lite_resp_t rresp,
  input  logic           rvalid,
  output logic           rready
);

  if (TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("axi_lite_master: TIMEOUT_CYCLES must be non-zero");
  end

  axi_master_state_e state_q, state_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d;
  axi_lite_addr_t    awaddr_d, araddr_d;
  axi_lite_data_t    wdata_d, rsp_rdata_d;
  axi_lite_strb_t    wstrb_d;
  logic              rsp_valid_d;
  axi_lite_resp_t    rsp_resp_d;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             wd_busy;
  logic             timeout_hit;
  logic             rsp_timeout_d;
`endif

  assign cmd_ready = (state_q == IDLE) && !rst;

  // Next-state and next-output logic; every registered output holds by default.
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = awvalid;
    wvalid_d    = wvalid;
    arvalid_d   = arvalid;
    bready_d    = bready;
    rready_d    = rready;
    awaddr_d    = awaddr;
    wdata_d     = wdata;
    wstrb_d     = wstrb;
    araddr_d    = araddr;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_write) begin
            state_d   = WR_REQ;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_REQ;
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // Each channel drops its valid independently after its own handshake.
        if (awvalid && awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid && wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = bresp;
        end
      end
      RD_REQ: begin
        if (arready) begin
          state_d   = RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_RESP: begin
        if (rvalid) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rdata;
          rsp_resp_d  = rresp;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef AXI_MASTER_TIMEOUT_EN
    // Watchdog: abort any channel wait that lasts TIMEOUT_CYCLES cycles.
    wd_busy       = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                    (state_q == RD_REQ) || (state_q == RD_RESP);
    timeout_hit   = wd_busy && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    rsp_timeout_d = rsp_timeout;
    if ((state_d == RSP) && (state_q != RSP)) begin
      rsp_timeout_d = 1'b0;
    end
    if (timeout_hit) begin
      state_d       = RSP;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      arvalid_d     = 1'b0;
      bready_d      = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = AXI_RESP_DECERR;
      rsp_timeout_d = 1'b1;
    end
    wd_cnt_d = ((state_d != state_q) || !wd_busy) ? '0 : wd_cnt_q + CNT_W'(1);
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      arvalid   <= 1'b0;
      bready    <= 1'b0;
      rready    <= 1'b0;
      awaddr    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      araddr    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= AXI_RESP_OKAY;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awvalid   <= awvalid_d;
      wvalid    <= wvalid_d;
      arvalid   <= arvalid_d;
      bready    <= bready_d;
      rready    <= rready_d;
      awaddr    <= awaddr_d;
      wdata     <= wdata_d;
      wstrb     <= wstrb_d;
      araddr    <= araddr_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_resp  <= rsp_resp_d;
    end
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  // Watchdog counter and timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      wd_cnt_q    <= wd_cnt_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master against a small AXI4-Lite register
// slave with programmable AW/W stall, AR blocking and forced responses.
module tb_axi_lite_master;
  import axi4_lite_pkg::*;

  localparam int unsigned TO_CYC     = 16;
  localparam int          WAIT_LIMIT = 200;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic           cmd_write = 1'b0;
  axi_lite_addr_t cmd_addr  = '0;
  axi_lite_data_t cmd_wdata = '0;
  axi_lite_strb_t cmd_wstrb = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  axi_lite_data_t rsp_rdata;
  axi_lite_resp_t rsp_resp;
  logic           rsp_timeout;
  axi_lite_addr_t awaddr;
  logic           awvalid, awready;
  axi_lite_data_t wdata;
  axi_lite_strb_t wstrb;
  logic           wvalid, wready;
  axi_lite_resp_t bresp;
  logic           bvalid, bready;
  axi_lite_addr_t araddr;
  logic           arvalid, arready;
  axi_lite_data_t rdata;
  axi_lite_resp_t rresp;
  logic           rvalid, rready;

  int vecs = 0;
  int errs = 0;

  // Slave configuration, driven by the stimulus.
  int             aw_stall = 0;
  int             w_stall  = 0;
  logic           ar_block = 1'b0;
  logic           r_force  = 1'b0;
  axi_lite_data_t r_force_data = '0;
  axi_lite_resp_t r_resp_cfg   = AXI_RESP_OKAY;
  axi_lite_resp_t b_resp_cfg   = AXI_RESP_OKAY;

  // Per-transaction observations.
  int             lat, n_aw, n_w, n_ar, first_b, first_r;
  axi_lite_addr_t seen_awaddr, seen_araddr;
  axi_lite_data_t seen_wdata;
  axi_lite_strb_t seen_wstrb;
  int             b0;

  always #5 clk = ~clk;

  axi_lite_master #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  // ---------------- slave model ----------------
  axi_lite_data_t mem [8];
  int             aw_wait, w_wait, b_hs;
  logic           got_aw, got_w;
  logic [2:0]     lat_idx;
  axi_lite_data_t lat_wdata;
  axi_lite_strb_t lat_wstrb;
  logic [2:0]     wr_idx;
  axi_lite_data_t wr_data;
  axi_lite_strb_t wr_strb;

  assign awready = awvalid && (aw_wait >= aw_stall);
  assign wready  = wvalid && (w_wait >= w_stall);
  assign arready = arvalid && !ar_block;
  assign wr_idx  = (awvalid && awready) ? awaddr[2:0] : lat_idx;
  assign wr_data = (wvalid && wready) ? wdata : lat_wdata;
  assign wr_strb = (wvalid && wready) ? wstrb : lat_wstrb;

  function automatic axi_lite_data_t merge(axi_lite_data_t old, axi_lite_data_t nw,
                                           axi_lite_strb_t s);
    axi_lite_data_t r = old;
    for (int i = 0; i < int'(AXI_STRB_W); i++) if (s[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; b_hs <= 0;
      got_aw <= 1'b0; got_w <= 1'b0;
      lat_idx <= '0; lat_wdata <= '0; lat_wstrb <= '0;
      bvalid <= 1'b0; bresp <= '0;
      rvalid <= 1'b0; rdata <= '0; rresp <= '0;
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
      if (awvalid && awready) begin got_aw <= 1'b1; lat_idx <= awaddr[2:0]; end
      if (wvalid && wready) begin got_w <= 1'b1; lat_wdata <= wdata; lat_wstrb <= wstrb; end
      if ((got_aw || (awvalid && awready)) && (got_w || (wvalid && wready)) && !bvalid) begin
        mem[wr_idx] <= merge(mem[wr_idx], wr_data, wr_strb);
        bvalid <= 1'b1;
        bresp  <= b_resp_cfg;
        got_aw <= 1'b0;
        got_w  <= 1'b0;
      end
      if (bvalid && bready) begin bvalid <= 1'b0; b_hs <= b_hs + 1; end
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= r_force ? r_force_data : mem[araddr[2:0]];
        rresp  <= r_resp_cfg;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command at a negedge; returns just after the accepting edge.
  task automatic issue(input logic wr, input axi_lite_addr_t a, input axi_lite_data_t d);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = 4'hF;
    for (int k = 0; k < WAIT_LIMIT && !cmd_ready; k++) @(negedge clk);
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
  endtask

  // Sample every cycle after accept until rsp_valid; lat = cycles after accept.
  task automatic wait_rsp();
    lat = 0; n_aw = 0; n_w = 0; n_ar = 0; first_b = 0; first_r = 0;
    for (int k = 1; k <= WAIT_LIMIT; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (awvalid) begin n_aw++; seen_awaddr = awaddr; end
      if (wvalid) begin n_w++; seen_wdata = wdata; seen_wstrb = wstrb; end
      if (arvalid) begin n_ar++; seen_araddr = araddr; end
      if (bready && first_b == 0) first_b = k;
      if (rready && first_r == 0) first_r = k;
      if (rsp_valid) begin lat = k; break; end
      @(posedge clk);
    end
    chk("rsp_arrives", 32'(lat != 0), 32'd1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_dropped", 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_write(input axi_lite_addr_t a, input axi_lite_data_t d,
                          input int exp_lat, input axi_lite_resp_t exp_resp);
    issue(1'b1, a, d);
    wait_rsp();
    chk("wr_latency", 32'(lat), 32'(exp_lat));
    chk("wr_awaddr", seen_awaddr, a);
    chk("wr_wdata", seen_wdata, d);
    chk("wr_wstrb", 32'(seen_wstrb), 32'hF);
    chk("wr_resp", 32'(rsp_resp), 32'(exp_resp));
    chk("wr_rdata_zero", rsp_rdata, 32'h0);
    chk("wr_timeout", 32'(rsp_timeout), 32'd0);
    consume();
  endtask

  task automatic do_read(input axi_lite_addr_t a, input axi_lite_data_t exp_d,
                         input axi_lite_resp_t exp_resp);
    issue(1'b0, a, '0);
    wait_rsp();
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_rready_cycle", 32'(first_r), 32'd2);
    chk("rd_ar_cycles", 32'(n_ar), 32'd1);
    chk("rd_araddr", seen_araddr, a);
    chk("rd_rdata", rsp_rdata, exp_d);
    chk("rd_resp", 32'(rsp_resp), 32'(exp_resp));
    chk("rd_timeout", 32'(rsp_timeout), 32'd0);
    consume();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_ctrl", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_timeout}), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_resp", 32'(rsp_resp), 32'd0);
    chk("rst_awaddr", awaddr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_wstrb", 32'(wstrb), 32'h0);
    chk("rst_araddr", araddr, 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Zero-wait writes: AW and W accepted together, bready two cycles in
    do_write(32'h3, 32'h83, 3, AXI_RESP_OKAY);
    chk("sim_aw_cycles", 32'(n_aw), 32'd1);
    chk("sim_w_cycles", 32'(n_w), 32'd1);
    chk("sim_bready_cycle", 32'(first_b), 32'd2);
    do_write(32'h0, 32'hAA, 3, AXI_RESP_OKAY);
    do_read(32'h0, 32'hAA, AXI_RESP_OKAY);

    // AW stalled 3 cycles, W immediate
    aw_stall = 3;
    b0 = b_hs;
    do_write(32'h1, 32'h55, 6, AXI_RESP_OKAY);
    chk("awstall_aw_cycles", 32'(n_aw), 32'd4);
    chk("awstall_w_cycles", 32'(n_w), 32'd1);
    chk("awstall_bready_cycle", 32'(first_b), 32'd5);
    chk("awstall_b_handshakes", 32'(b_hs - b0), 32'd1);
    aw_stall = 0;

    // W stalled 2 cycles, AW immediate
    w_stall = 2;
    do_write(32'h2, 32'h3C, 5, AXI_RESP_OKAY);
    chk("wstall_aw_cycles", 32'(n_aw), 32'd1);
    chk("wstall_w_cycles", 32'(n_w), 32'd3);
    chk("wstall_bready_cycle", 32'(first_b), 32'd4);
    w_stall = 0;

    // Response backpressure with a second command waiting
    issue(1'b0, 32'h1, '0);
    wait_rsp();
    chk("bp_first_rdata", rsp_rdata, 32'h55);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h55);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_no_ar", 32'(arvalid), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_released_valid", 32'(rsp_valid), 32'd0);
    chk("bp_released_ready", 32'(cmd_ready), 32'd1);
    chk("bp_second_not_yet", 32'(arvalid), 32'd0);
    @(posedge clk);
    wait_rsp();
    chk("bp_second_latency", 32'(lat), 32'd3);
    chk("bp_second_araddr", seen_araddr, 32'h0);
    chk("bp_second_rdata", rsp_rdata, 32'hAA);
    consume();

    // Error responses pass straight through
    r_force = 1'b1; r_force_data = 32'h12; r_resp_cfg = AXI_RESP_SLVERR;
    do_read(32'h4, 32'h12, AXI_RESP_SLVERR);
    r_force = 1'b0; r_resp_cfg = AXI_RESP_OKAY;
    b_resp_cfg = AXI_RESP_DECERR;
    do_write(32'h5, 32'h99, 3, AXI_RESP_DECERR);
    b_resp_cfg = AXI_RESP_OKAY;

    // Reset in the middle of a stalled read
    ar_block = 1'b1;
    issue(1'b0, 32'h5, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("stall_arvalid_held", 32'(arvalid), 32'd1);
      chk("stall_araddr", araddr, 32'h5);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ctrl", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ar_block = 1'b0;
    #1;
    chk("midrst_release_ready", 32'(cmd_ready), 32'd1);
    do_read(32'h0, 32'h0, AXI_RESP_OKAY);
    do_write(32'h6, 32'h77, 3, AXI_RESP_OKAY);
    do_read(32'h6, 32'h77, AXI_RESP_OKAY);

`ifdef AXI_MASTER_TIMEOUT_EN
    // Watchdog on a read whose address is never accepted
    ar_block = 1'b1;
    issue(1'b0, 32'h7, '0);
    wait_rsp();
    chk("to_ar_cycles", 32'(n_ar), 32'(TO_CYC));
    chk("to_latency", 32'(lat), 32'(TO_CYC + 1));
    chk("to_resp", 32'(rsp_resp), 32'(AXI_RESP_DECERR));
    chk("to_flag", 32'(rsp_timeout), 32'd1);
    chk("to_rdata", rsp_rdata, 32'h0);
    consume();
    ar_block = 1'b0;
    do_read(32'h6, 32'h77, AXI_RESP_OKAY);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

Single-outstanding AXI4-Lite initiator that converts a simple command/response port into AXI4-Lite read and write transactions. It sits on the host side of the UART register bus and drives `axi_ui` (the 16550 register slave) from a local controller, sequencer or bridge. It issues one transaction at a time, supports independent AW/W acceptance, and returns read data and response codes to the requester.

## Interface
- `TIMEOUT_CYCLES`, 256: cycles to wait on any single AXI channel handshake before abort (used only with the watchdog).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when high with `cmd_valid`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in `axi_lite_addr_t`: target address.
- `cmd_wdata` in `axi_lite_data_t`: write data.
- `cmd_wstrb` in `axi_lite_strb_t`: write strobes.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out `axi_lite_data_t`: read data; 0 for writes.
- `rsp_resp` out `axi_lite_resp_t`: BRESP/RRESP, or DECERR on timeout.
- `rsp_timeout` out 1: response produced by the watchdog.
- AW channel: `awaddr` out, `awvalid` out, `awready` in.
- W channel: `wdata` out, `wstrb` out, `wvalid` out, `wready` in.
- B channel: `bresp` in, `bvalid` in, `bready` out.
- AR channel: `araddr` out, `arvalid` out, `arready` in.
- R channel: `rdata` in, `rresp` in, `rvalid` in, `rready` out.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: `cmd_ready = (state==IDLE) && !rst`. On `cmd_valid && cmd_ready`, latch addr/data/strb. Next state is WR_REQ if `cmd_write`, else RD_REQ.
- WR_REQ:
  - `awvalid` and `wvalid` are both asserted on entry.
  - Each is dropped the cycle after its own handshake, tracked by flags `aw_done` and `w_done`.
  - AW and W may complete in either order or in the same cycle.
  - Go to WR_RESP when both are done.
- WR_RESP: `bready=1`. On `bvalid`, capture `bresp`, set `rsp_rdata=0`, go to RSP.
- RD_REQ: `arvalid=1` until the AR handshake, then go to RD_RESP.
- RD_RESP: `rready=1`. On `rvalid`, capture `rdata`/`rresp`, go to RSP.
- RSP:
  - `rsp_valid=1`; data and response are held stable until `rsp_ready`.
  - On `rsp_ready`, go to IDLE.
  - A new command can be accepted no earlier than the cycle after `rsp_ready`.
- Once asserted, `awvalid`, `wvalid` and `arvalid` never drop before their handshake (AXI rule). Address, data and strobes are held stable while valid.
- Responses are not interpreted. SLVERR/DECERR from the slave are passed through with `rsp_timeout=0`.

## Timing
- Reset values:
  - State IDLE.
  - All `*valid` outputs 0; `bready` 0, `rready` 0.
  - `rsp_valid` 0, `rsp_rdata` 0, `rsp_resp` 2'b00, `rsp_timeout` 0.
  - `awaddr`, `wdata`, `wstrb`, `araddr` all 0.
- All outputs are registered except `cmd_ready`.
- Zero-wait slave: command accepted at edge N; AW/W valid in cycle N+1; `bready` in N+2; `rsp_valid` in N+3 if `bvalid` is high in N+2. Reads follow the same pattern.
- Reset mid-transaction: on the next edge all valids and readys drop and the state returns to IDLE. Any pending slave response is abandoned; the bench must reset the slave as well.

## Configuration
- `AXI_MASTER_TIMEOUT_EN` defined: the watchdog is compiled in.
  - A counter clears on every state change and counts cycles spent in WR_REQ, WR_RESP, RD_REQ or RD_RESP.
  - When it reaches `TIMEOUT_CYCLES-1`, all valids and readys drop and the FSM enters RSP with `rsp_resp=2'b11`, `rsp_timeout=1`, `rsp_rdata=0`.
- Not defined: no counter; the master waits indefinitely and `rsp_timeout` is tied to 0.

## Structure
- Use `axi_lite_addr_t`, `axi_lite_data_t`, `axi_lite_strb_t` and `axi_lite_resp_t` from `axi4_lite_pkg`.
- Add to `axi4_lite_pkg`:
  - Response constants `AXI_RESP_OKAY`, `AXI_RESP_SLVERR`, `AXI_RESP_DECERR`.
  - FSM enum `axi_master_state_e`.
- No sub-module; the watchdog counter stays inline under the macro.

## Test plan
- Back-to-back with `axi_ui`, default strobes 4'b1111:
  - Write LCR (addr 3) = 0x83, then write DLL (addr 0) = 0xAA.
  - Read addr 0 → `rsp_rdata[7:0]=0xAA`, `rsp_resp=00`.
  - With a zero-wait slave, `rsp_valid` is asserted 3 cycles after command accept.
- Stalled AW: delay `awready` 3 cycles while `wready` is immediate.
  - `wvalid` is high 1 cycle only; `awvalid` is held for 4 cycles.
  - Exactly one B handshake occurs; `rsp_resp=00`.
- Simultaneous AW/W acceptance in one cycle → both valids drop on the next cycle and WR_RESP is entered.
- Response backpressure: hold `rsp_ready=0` for 5 cycles.
  - `rsp_valid`, `rsp_rdata` and `cmd_ready=0` stay stable throughout.
  - A second `cmd_valid` is not accepted until after `rsp_ready`.
- Slave returns `rresp=2'b10` with `rdata=0x12` → `rsp_resp=10`, `rsp_rdata=0x12`, `rsp_timeout=0`.
- With `AXI_MASTER_TIMEOUT_EN` and `TIMEOUT_CYCLES=16`, hold `arready=0`:
  - `arvalid` drops after 16 cycles.
  - Response is `rsp_resp=11`, `rsp_timeout=1`.
  - Assert `rst` mid-read → all valids are 0 on the next edge and `cmd_ready=1` after reset release.
